alert_arbiter: RTL and testbench
================================

Name: alert_arbiter

Overview:
- Shares the single front-panel buzzer between the alarm and countdown-timer event sources.
- Sits between the alarm/timer buzzer pulses of digital_clock and the speaker pin.
- Sequences ringing with priority, ring timeout, stop and snooze. Tracks pending events and the snooze countdown.
- clk is the 1 Hz system tick, so one cycle = one second.

Parameters:
- RING_SECS, 30: cycles a source rings before auto-stop (1..511).
- SNOOZE_SECS, 300: snooze delay in cycles (1..1023).
- MAX_SNOOZE, 3: snoozes allowed per alarm occurrence (0..3).

Ports:
- clk  in  1  system clock (1 Hz tick)
- reset  in  1  asynchronous, active-low reset; clears all state while low
- alarm_evt  in  1  one-cycle pulse from the alarm comparator
- timer_evt  in  1  one-cycle pulse from the countdown timer expiry
- alarm_enable  in  1  level; 0 disables alarm ringing and snooze
- stop_btn  in  1  one-cycle pulse, already debounced
- snooze_btn  in  1  one-cycle pulse, already debounced
- buzzer  out  1  speaker drive, registered
- ring_src  out  2  0 none, 1 alarm, 2 timer (3 unused)
- snooze_active  out  1  snooze countdown running
- snooze_count  out  2  snoozes used on the current alarm
- secs_left  out  9  RING_SECS minus elapsed ring cycles; 0 when idle

Behaviour:
- Reset (reset low, async): state IDLE. All outputs 0; pending_alarm, pending_timer, ring_cnt and snooze_cnt all 0.
- FSM states: IDLE, RING_ALARM, RING_TIMER.
- Pending latches:
  - pending_alarm sets on (alarm_evt & alarm_enable) or on snooze expiry.
  - pending_timer sets on timer_evt.
  - Each latch clears when its source enters RING.
  - Duplicate events while already pending or ringing the same source are absorbed (no restart).
- IDLE:
  - On the same edge an event is seen (latched or incoming), enter RING.
  - Alarm has priority over timer.
  - On entry: ring_cnt = 0; buzzer, ring_src and secs_left = RING_SECS are valid after that edge (latency 1 edge from event).
- RING_ALARM:
  - buzzer is continuously 1.
  - ring_cnt increments each cycle; secs_left = RING_SECS - ring_cnt.
  - stop_btn: go to IDLE; clear snooze_count and snooze_cnt.
  - snooze_btn with snooze_count < MAX_SNOOZE: load snooze_cnt = SNOOZE_SECS, increment snooze_count, go to IDLE.
  - snooze_btn with snooze_count == MAX_SNOOZE: treated as stop.
  - Timeout (ring_cnt == RING_SECS-1 at an edge): behaves as stop.
  - alarm_enable low: behaves as stop.
- RING_TIMER:
  - buzzer = ~ring_cnt[0], i.e. beeps 1,0,1,0 starting at 1.
  - stop_btn or timeout: go to IDLE.
  - snooze_btn is ignored.
  - An alarm event during timer ringing becomes pending. It does not pre-empt.
- Leaving RING always passes through one IDLE cycle (buzzer 0) before a pending source is served.
- Simultaneous events:
  - stop_btn and snooze_btn together: stop wins.
  - alarm_evt and timer_evt together: alarm rings, timer pending.
  - Snooze expiry and alarm_evt together: a single pending alarm.
- Snooze counter:
  - Independent 10-bit down-counter; decrements every cycle while nonzero. snooze_active = (snooze_cnt != 0).
  - Transition 1->0 sets pending_alarm.
  - Keeps counting while the timer rings.
  - alarm_enable low clears snooze_cnt, snooze_count and pending_alarm.
- A fresh alarm_evt (not a snooze re-ring) clears snooze_count to 0 on RING entry.
- Widths and arithmetic: ring_cnt is 9 bits, snooze_cnt 10 bits. No wrap is possible inside the legal parameter ranges. Out-of-range parameters are an elaboration error.
- Reset asserted mid-ring: buzzer drops immediately and asynchronously; all pending events are lost.

Decomposition:
- Shared package alert_pkg:
  - ring_src encoding constants SRC_NONE/SRC_ALARM/SRC_TIMER.
  - FSM state enum.
- Sub-module alert_snooze_timer: loadable down-counter with expiry pulse and active flag, parameterised on width.

Test Plan (overrides RING_SECS=5, SNOOZE_SECS=4, MAX_SNOOZE=2):
- alarm_evt at cycle 10, no buttons -> buzzer=1 and ring_src=1 for cycles 11-15, secs_left 5,4,3,2,1; then buzzer=0, ring_src=0.
- timer_evt at cycle 3 -> buzzer pattern 1,0,1,0,1 on cycles 4-8; snooze_btn at cycle 5 has no effect.
- alarm_evt and timer_evt both at cycle 2 -> alarm rings cycles 3-7; IDLE at cycle 8; timer rings cycles 9-13.
- alarm rings, snooze_btn at cycle 2 of ring -> IDLE, snooze_active=1, snooze_count=1; re-ring 4 cycles later plus 1 entry edge. A second snooze gives count=2. A third snooze stops: count=0, snooze_active=0.
- During snooze, timer_evt arrives -> timer rings while snooze keeps counting. Snooze expiry during timer ring -> alarm pending, rings after timer ends plus one IDLE cycle.
- alarm ringing, alarm_enable driven 0 -> buzzer=0 next edge, pending and snooze cleared. reset pulsed low mid-ring -> all outputs 0 immediately.

Source files
------------

// File: rtl/alert_pkg.sv
// alert_pkg
// Shared definitions for the buzzer arbiter.
//   - ring_src encoding driven onto the speaker-source status output
//   - FSM state type used by alert_arbiter
package alert_pkg;

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_ALARM = 2'd1;
    localparam logic [1:0] SRC_TIMER = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RING_ALARM = 2'd1,
        ST_RING_TIMER = 2'd2
    } state_e;

endpackage

// File: rtl/alert_arbiter_if.sv
// alert_arbiter_if
// Event/button inputs and buzzer status outputs of the alert arbiter.
//   alarm_evt, timer_evt   one-cycle event pulses
//   alarm_enable           level, 0 disables alarm ringing and snooze
//   stop_btn, snooze_btn   one-cycle debounced button pulses
//   buzzer                 speaker drive
//   ring_src               0 none, 1 alarm, 2 timer
//   snooze_active          snooze countdown running
//   snooze_count           snoozes used on the current alarm
//   secs_left              remaining ring seconds, 0 when idle
// master: the event/button side; slave: the arbiter.
interface alert_arbiter_if;

    logic       alarm_evt;
    logic       timer_evt;
    logic       alarm_enable;
    logic       stop_btn;
    logic       snooze_btn;
    logic       buzzer;
    logic [1:0] ring_src;
    logic       snooze_active;
    logic [1:0] snooze_count;
    logic [8:0] secs_left;

    modport master (
        output alarm_evt, timer_evt, alarm_enable, stop_btn, snooze_btn,
        input  buzzer, ring_src, snooze_active, snooze_count, secs_left
    );

    modport slave (
        input  alarm_evt, timer_evt, alarm_enable, stop_btn, snooze_btn,
        output buzzer, ring_src, snooze_active, snooze_count, secs_left
    );

endinterface

// File: rtl/alert_snooze_timer.sv
// alert_snooze_timer
// Loadable down-counter that runs to zero and stops there.
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load load_val this edge
//   load_val    reload value
//   clear       force the count to zero this edge (wins over load)
//   active      count is nonzero
//   expire      count is 1, i.e. the coming edge takes it 1 -> 0
module alert_snooze_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic             active,
    output logic             expire
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active = (cnt_q != '0);
    // Raw transition flag; callers decide whether a 1 -> 0 step counts.
    assign expire = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/alert_arbiter.sv
// alert_arbiter
// Shares the front-panel buzzer between the alarm and the countdown timer.
// clk is the 1 Hz tick, so every count below is in seconds.
//   clk    1 Hz system tick
//   reset  asynchronous active-low reset
//   bus    alert_arbiter_if.slave: event/button inputs, buzzer status outputs
//
// state          | meaning
// ST_IDLE        | buzzer off; serves a pending/incoming source, alarm first
// ST_RING_ALARM  | buzzer steady on; stop, snooze, timeout or disable end it
// ST_RING_TIMER  | buzzer beeps 1,0,1,0...; stop or timeout end it
module alert_arbiter
    import alert_pkg::*;
#(
    parameter int RING_SECS   = 30,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic           clk,
    input  logic           reset,
    alert_arbiter_if.slave bus
);

    if (RING_SECS < 1 || RING_SECS > 511 || SNOOZE_SECS < 1 || SNOOZE_SECS > 1023 ||
        MAX_SNOOZE < 0 || MAX_SNOOZE > 3) begin : g_param_check
        $error("alert_arbiter: parameter out of range");
    end

    localparam logic [8:0] RING_FULL   = 9'(RING_SECS);
    localparam logic [8:0] RING_LAST   = 9'(RING_SECS - 1);
    localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_SECS);
    localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

    state_e     state_q, state_d;
    logic [8:0] ring_cnt_q, ring_cnt_d;
    logic       buzzer_q, buzzer_d;
    logic       pending_alarm_q, pending_alarm_d;
    logic       pending_fresh_q, pending_fresh_d;
    logic       pending_timer_q, pending_timer_d;
    logic [1:0] snooze_count_q, snooze_count_d;

    logic snz_load;
    logic snz_clear;
    logic snz_active;
    logic snz_expire;

    alert_snooze_timer #(.WIDTH(10)) u_snooze (
        .clk      (clk),
        .rst_n    (reset),
        .load     (snz_load),
        .load_val (SNOOZE_LOAD),
        .clear    (snz_clear),
        .active   (snz_active),
        .expire   (snz_expire)
    );

    always_comb begin
        state_d         = state_q;
        ring_cnt_d      = ring_cnt_q;
        buzzer_d        = 1'b0;
        pending_alarm_d = pending_alarm_q;
        pending_fresh_d = pending_fresh_q;
        pending_timer_d = pending_timer_q;
        snooze_count_d  = snooze_count_q;
        snz_load        = 1'b0;
        snz_clear       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ring_cnt_d = '0;
                if (bus.alarm_enable && (pending_alarm_q || bus.alarm_evt || snz_expire)) begin
                    state_d         = ST_RING_ALARM;
                    buzzer_d        = 1'b1;
                    pending_alarm_d = 1'b0;
                    pending_fresh_d = 1'b0;
                    pending_timer_d = pending_timer_q | bus.timer_evt;
                    // A real alarm occurrence restarts the snooze budget;
                    // a snooze re-ring keeps it.
                    if (pending_fresh_q || bus.alarm_evt) begin
                        snooze_count_d = '0;
                    end
                end else if (pending_timer_q || bus.timer_evt) begin
                    state_d         = ST_RING_TIMER;
                    buzzer_d        = 1'b1;
                    pending_timer_d = 1'b0;
                end
            end

            ST_RING_ALARM: begin
                pending_timer_d = pending_timer_q | bus.timer_evt;
                if (!bus.alarm_enable || bus.stop_btn ||
                    (bus.snooze_btn && snooze_count_q >= SNOOZE_MAX) ||
                    (!bus.snooze_btn && ring_cnt_q == RING_LAST)) begin
                    state_d        = ST_IDLE;
                    ring_cnt_d     = '0;
                    snooze_count_d = '0;
                    snz_clear      = 1'b1;
                end else if (bus.snooze_btn) begin
                    state_d        = ST_IDLE;
                    ring_cnt_d     = '0;
                    snooze_count_d = snooze_count_q + 2'd1;
                    snz_load       = 1'b1;
                end else begin
                    ring_cnt_d = ring_cnt_q + 9'd1;
                    buzzer_d   = 1'b1;
                end
            end

            ST_RING_TIMER: begin
                // Alarm requests queue behind the timer instead of pre-empting.
                pending_alarm_d = pending_alarm_q | bus.alarm_evt | snz_expire;
                pending_fresh_d = pending_fresh_q | bus.alarm_evt;
                if (bus.stop_btn || ring_cnt_q == RING_LAST) begin
                    state_d    = ST_IDLE;
                    ring_cnt_d = '0;
                end else begin
                    ring_cnt_d = ring_cnt_q + 9'd1;
                    buzzer_d   = ~ring_cnt_d[0];
                end
            end

            default: begin
                state_d    = ST_IDLE;
                ring_cnt_d = '0;
            end
        endcase

        if (!bus.alarm_enable) begin
            snz_load        = 1'b0;
            snz_clear       = 1'b1;
            snooze_count_d  = '0;
            pending_alarm_d = 1'b0;
            pending_fresh_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            ring_cnt_q      <= '0;
            buzzer_q        <= 1'b0;
            pending_alarm_q <= 1'b0;
            pending_fresh_q <= 1'b0;
            pending_timer_q <= 1'b0;
            snooze_count_q  <= '0;
        end else begin
            state_q         <= state_d;
            ring_cnt_q      <= ring_cnt_d;
            buzzer_q        <= buzzer_d;
            pending_alarm_q <= pending_alarm_d;
            pending_fresh_q <= pending_fresh_d;
            pending_timer_q <= pending_timer_d;
            snooze_count_q  <= snooze_count_d;
        end
    end

    always_comb begin
        bus.ring_src = SRC_NONE;
        case (state_q)
            ST_RING_ALARM: bus.ring_src = SRC_ALARM;
            ST_RING_TIMER: bus.ring_src = SRC_TIMER;
            default:       bus.ring_src = SRC_NONE;
        endcase
    end

    assign bus.buzzer        = buzzer_q;
    assign bus.snooze_active = snz_active;
    assign bus.snooze_count  = snooze_count_q;
    assign bus.secs_left     = (state_q == ST_IDLE) ? 9'd0 : (RING_FULL - ring_cnt_q);

endmodule

// File: tb/tb_alert_arbiter.sv
// Bench for alert_arbiter with RING_SECS=5, SNOOZE_SECS=4, MAX_SNOOZE=2.
// A second-by-second behavioural model tracks which source is sounding,
// how long it has sounded, what is queued and how long the snooze has left;
// every cycle the outputs are compared against it. Directed sequences pin
// the model with literal expectations, then random traffic follows.
module tb_alert_arbiter;

    localparam int RING = 5;
    localparam int SNZ  = 4;
    localparam int MAXS = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    bit   chk_en = 1'b0;

    alert_arbiter_if bus();

    alert_arbiter #(
        .RING_SECS   (RING),
        .SNOOZE_SECS (SNZ),
        .MAX_SNOOZE  (MAXS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_mode: 0 silent, 1 alarm sounding, 2 timer sounding
    int m_mode, m_elapsed, m_used, m_snz;
    bit m_pa, m_pf, m_pt;

    task automatic alarm_off();
        m_mode = 0;
        m_used = 0;
        m_snz  = 0;
    endtask

    task automatic model_step();
        bit en;
        bit expiring;
        en       = bus.alarm_enable;
        expiring = (m_snz == 1);
        if (m_snz > 0) m_snz--;
        case (m_mode)
            0: begin
                if (en && (m_pa || bus.alarm_evt || expiring)) begin
                    if (m_pf || bus.alarm_evt) m_used = 0;
                    m_mode = 1; m_elapsed = 0; m_pa = 0; m_pf = 0;
                    m_pt = m_pt || bus.timer_evt;
                end else if (m_pt || bus.timer_evt) begin
                    m_mode = 2; m_elapsed = 0; m_pt = 0;
                end
            end
            1: begin
                m_pt = m_pt || bus.timer_evt;
                if (!en || bus.stop_btn) alarm_off();
                else if (bus.snooze_btn && m_used < MAXS) begin
                    m_used++; m_snz = SNZ; m_mode = 0;
                end
                else if (bus.snooze_btn) alarm_off();
                else if (m_elapsed == RING - 1) alarm_off();
                else m_elapsed++;
            end
            default: begin
                m_pa = m_pa || bus.alarm_evt || expiring;
                m_pf = m_pf || bus.alarm_evt;
                if (bus.stop_btn || m_elapsed == RING - 1) m_mode = 0;
                else m_elapsed++;
            end
        endcase
        if (!en) begin
            m_snz = 0; m_used = 0; m_pa = 0; m_pf = 0;
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_elapsed = 0; m_used = 0; m_snz = 0;
            m_pa = 0; m_pf = 0; m_pt = 0;
        end else begin
            model_step();
        end
    end

    function automatic int exp_buzzer();
        if (m_mode == 1) return 1;
        if (m_mode == 2) return (m_elapsed % 2 == 0) ? 1 : 0;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (chk_en && reset) begin
            chk("m_buzzer",        bus.buzzer,        exp_buzzer());
            chk("m_ring_src",      bus.ring_src,      m_mode);
            chk("m_secs_left",     bus.secs_left,     (m_mode != 0) ? RING - m_elapsed : 0);
            chk("m_snooze_active", bus.snooze_active, (m_snz != 0) ? 1 : 0);
            chk("m_snooze_count",  bus.snooze_count,  m_used);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit a, input bit t, input bit st, input bit sz, input bit en = 1'b1);
        bus.alarm_evt    = a;
        bus.timer_evt    = t;
        bus.stop_btn     = st;
        bus.snooze_btn   = sz;
        bus.alarm_enable = en;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_buzzer"},   bus.buzzer,        0);
        chk({tag, "_src"},      bus.ring_src,      0);
        chk({tag, "_secs"},     bus.secs_left,     0);
        chk({tag, "_active"},   bus.snooze_active, 0);
        chk({tag, "_count"},    bus.snooze_count,  0);
    endtask

    int pat[5] = '{1, 0, 1, 0, 1};
    bit en_lvl;

    initial begin
        bus.alarm_evt    = 1'b0;
        bus.timer_evt    = 1'b0;
        bus.stop_btn     = 1'b0;
        bus.snooze_btn   = 1'b0;
        bus.alarm_enable = 1'b1;

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset  = 1'b1;
        chk_en = 1'b1;

        // Alarm rings RING seconds with secs_left counting down, then stops.
        idle(3);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("alarm_buzzer", bus.buzzer,    1);
            chk("alarm_src",    bus.ring_src,  1);
            chk("alarm_secs",   bus.secs_left, 5 - i);
            idle(1);
        end
        chk("alarm_end_buzzer", bus.buzzer,   0);
        chk("alarm_end_src",    bus.ring_src, 0);

        // Timer beeps 1,0,1,0,1; snooze during ring is ignored.
        idle(2);
        drive(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("timer_buzzer", bus.buzzer,   pat[i]);
            chk("timer_src",    bus.ring_src, 2);
            drive(0, 0, 0, (i == 1), 1);
        end
        chk("timer_end_src", bus.ring_src, 0);

        // Simultaneous events: alarm first, one idle cycle, then timer.
        idle(2);
        drive(1, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("both_alarm_src", bus.ring_src, 1);
            idle(1);
        end
        chk("both_gap_src",    bus.ring_src, 0);
        chk("both_gap_buzzer", bus.buzzer,   0);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            chk("both_timer_src",    bus.ring_src, 2);
            chk("both_timer_buzzer", bus.buzzer,   pat[i]);
            idle(1);
        end
        chk("both_end_src", bus.ring_src, 0);

        // Snooze sequence: two snoozes allowed, third one stops.
        idle(2);
        drive(1, 0, 0, 0);
        idle(1);
        chk("snz_ring2_secs", bus.secs_left, 4);
        drive(0, 0, 0, 1);
        chk("snz1_src",    bus.ring_src,      0);
        chk("snz1_active", bus.snooze_active, 1);
        chk("snz1_count",  bus.snooze_count,  1);
        idle(3);
        chk("snz1_wait_src", bus.ring_src, 0);
        idle(1);
        chk("snz1_rering_src",   bus.ring_src,     1);
        chk("snz1_rering_count", bus.snooze_count, 1);
        chk("snz1_rering_secs",  bus.secs_left,    5);
        drive(0, 0, 0, 1);
        chk("snz2_count",  bus.snooze_count,  2);
        chk("snz2_active", bus.snooze_active, 1);
        idle(4);
        chk("snz2_rering_src", bus.ring_src, 1);
        drive(0, 0, 0, 1);
        chk("snz3_src",    bus.ring_src,      0);
        chk("snz3_count",  bus.snooze_count,  0);
        chk("snz3_active", bus.snooze_active, 0);
        idle(6);
        chk("snz3_quiet_src", bus.ring_src, 0);

        // Snooze expires while the timer rings: alarm waits for timer + idle.
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 1, 0, 0);
        chk("st_timer_src",    bus.ring_src,      2);
        chk("st_timer_active", bus.snooze_active, 1);
        idle(2);
        chk("st_mid_src",    bus.ring_src,      2);
        chk("st_mid_active", bus.snooze_active, 1);
        idle(2);
        chk("st_late_src",    bus.ring_src,      2);
        chk("st_late_active", bus.snooze_active, 0);
        idle(1);
        chk("st_gap_src", bus.ring_src, 0);
        idle(1);
        chk("st_alarm_src",   bus.ring_src,     1);
        chk("st_alarm_count", bus.snooze_count, 1);
        drive(0, 0, 1, 0);
        chk("st_stop_src",   bus.ring_src,     0);
        chk("st_stop_count", bus.snooze_count, 0);

        // alarm_enable low cancels snooze and ringing.
        idle(2);
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 1);
        chk("en_snz_active", bus.snooze_active, 1);
        drive(0, 0, 0, 0, 0);
        chk("en_off_active", bus.snooze_active, 0);
        chk("en_off_count",  bus.snooze_count,  0);
        idle(6);
        chk("en_quiet_src", bus.ring_src, 0);
        drive(1, 0, 0, 0, 0);
        chk("en_masked_src", bus.ring_src, 0);
        drive(1, 0, 0, 0);
        chk("en_ring_src", bus.ring_src, 1);
        drive(0, 0, 0, 0, 0);
        chk("en_drop_buzzer", bus.buzzer,   0);
        chk("en_drop_src",    bus.ring_src, 0);
        idle(2);

        // Asynchronous reset mid-ring.
        drive(1, 0, 0, 0);
        idle(1);
        chk("rst_pre_buzzer", bus.buzzer, 1);
        #2 reset = 1'b0;
        #1 chk_all_zero("rst_async");
        @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Random traffic.
        en_lvl = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (en_lvl) begin
                if ($urandom_range(0, 79) == 0) en_lvl = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) en_lvl = 1'b1;
            end
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0, en_lvl);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
